serial_audio_encoder: RTL and testbench

//  Transmit side of the serial audio link. Accepts tagged PCM words on a valid/ready stream and drives

---
 rtl/serial_audio_pkg.sv | 25 ++
 rtl/serial_audio_encoder.sv | 173 +++++++++++++++++
 tb/tb_serial_audio_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_audio_pkg.sv
// Shared encodings for the serial audio link: slot-width codes, slot length and encoder FSM states.
package serial_audio_pkg;

    localparam logic [1:0] SW_16 = 2'd0;
    localparam logic [1:0] SW_24 = 2'd1;
    localparam logic [1:0] SW_32 = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Reserved code 3 behaves as a 32-bit slot.
    function automatic logic [5:0] slot_len(input logic [1:0] sw);
        logic [5:0] len;
        case (sw)
            SW_16:   len = 6'd16;
            SW_24:   len = 6'd24;
            SW_32:   len = 6'd32;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/serial_audio_encoder.sv
// Transmit side of the serial audio link: one-entry holding register feeding a slot shifter that
// drives lrclk_out/sdout as I2S or left-justified with 16/24/32-bit slots.
module serial_audio_encoder
    import serial_audio_pkg::*;
(
    input  logic        sclk,
    input  logic        reset,
    input  logic        is_i2s,
    input  logic        lrclk_polarity,
    input  logic [1:0]  slot_width,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic        i_is_left,
    input  logic [31:0] i_audio,
    output logic        lrclk_out,
    output logic        sdout,
    output logic        is_error
);

    state_t      state_r;
    state_t      state_s;

    logic        hold_full_r;
    logic        hold_left_r;
    logic [31:0] hold_audio_r;
    logic        ready_r;

    logic [31:0] shifter_r;
    logic [4:0]  bit_cnt_r;
    logic        left_r;
    logic        err_r;
    logic        lj_r;
    logic        sdout_r;

    logic        cfg_i2s_r;
    logic        cfg_pol_r;
    logic [1:0]  cfg_sw_r;

    logic        idle_go_s;
    logic        idle_drop_s;
    logic        slot_end_s;
    logic        slot_start_s;
    logic        next_left_s;
    logic        frame_start_s;
    logic        tag_ok_s;
    logic [31:0] load_word_s;
    logic        consume_s;
    logic        accept_s;
    logic        i2s_eff_s;
    logic        lj_next_s;
    logic        sdout_next_s;
    logic        pol_s;

    // FSM state register.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: leave IDLE only on a left-tagged entry; RUN is left only through reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_go_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: slot boundaries, holding-register consumption and the next serial bit.
    always_comb begin
        idle_go_s     = (state_r == ST_IDLE) && hold_full_r && hold_left_r;
        idle_drop_s   = (state_r == ST_IDLE) && hold_full_r && !hold_left_r;
        slot_end_s    = (state_r == ST_RUN) &&
                        ({1'b0, bit_cnt_r} == (slot_len(cfg_sw_r) - 6'd1));
        slot_start_s  = idle_go_s || slot_end_s;
        next_left_s   = idle_go_s ? 1'b1 : !left_r;
        frame_start_s = slot_start_s && next_left_s;
        tag_ok_s      = hold_full_r && (hold_left_r == next_left_s);
        load_word_s   = tag_ok_s ? hold_audio_r : 32'h0000_0000;
        consume_s     = (slot_start_s && hold_full_r) || idle_drop_s;
        accept_s      = i_valid && ready_r;
        // A frame start uses the freshly sampled mode, since the latch happens on that same edge.
        i2s_eff_s     = frame_start_s ? is_i2s : cfg_i2s_r;
        if (slot_start_s) begin
            lj_next_s = load_word_s[31];
        end else if (state_r == ST_RUN) begin
            lj_next_s = shifter_r[31];
        end else begin
            lj_next_s = 1'b0;
        end
        sdout_next_s  = i2s_eff_s ? lj_r : lj_next_s;
        pol_s         = (state_r == ST_IDLE) ? lrclk_polarity : cfg_pol_r;
    end

    // Holding register: filled by the input handshake, emptied when a slot start or IDLE takes it.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            hold_full_r  <= 1'b0;
            hold_left_r  <= 1'b0;
            hold_audio_r <= 32'h0000_0000;
            ready_r      <= 1'b1;
        end else if (consume_s) begin
            hold_full_r  <= 1'b0;
            ready_r      <= 1'b1;
        end else if (accept_s) begin
            hold_full_r  <= 1'b1;
            hold_left_r  <= i_is_left;
            hold_audio_r <= i_audio;
            ready_r      <= 1'b0;
        end
    end

    // Configuration is only sampled at left-slot starts so a frame never mixes settings.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            cfg_i2s_r <= 1'b0;
            cfg_pol_r <= 1'b0;
            cfg_sw_r  <= SW_32;
        end else if (frame_start_s) begin
            cfg_i2s_r <= is_i2s;
            cfg_pol_r <= lrclk_polarity;
            cfg_sw_r  <= slot_width;
        end
    end

    // Slot datapath: channel, bit counter, shifter and error flag.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            left_r    <= 1'b0;
            bit_cnt_r <= 5'd0;
            shifter_r <= 32'h0000_0000;
            err_r     <= 1'b0;
        end else if (slot_start_s) begin
            left_r    <= next_left_s;
            bit_cnt_r <= 5'd0;
            shifter_r <= {load_word_s[30:0], 1'b0};
            err_r     <= !tag_ok_s;
        end else if (state_r == ST_RUN) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
            shifter_r <= {shifter_r[30:0], 1'b0};
        end else if (idle_drop_s) begin
            err_r     <= 1'b1;
        end
    end

    // Serial output: lj_r holds the left-justified bit, which doubles as the one-cycle I2S delay.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            lj_r    <= 1'b0;
            sdout_r <= 1'b0;
        end else begin
            lj_r    <= lj_next_s;
            sdout_r <= sdout_next_s;
        end
    end

    // In IDLE the word clock follows the live polarity input so it reads !lrclk_polarity even in reset.
    assign lrclk_out = left_r ? pol_s : !pol_s;
    assign sdout     = sdout_r;
    assign i_ready   = ready_r;
    assign is_error  = err_r;

endmodule

// File: tb/tb_serial_audio_encoder.sv
// Directed bench for serial_audio_encoder: expected per-cycle {lrclk_out, sdout, is_error} are
// queued from the words fed in and checked cycle by cycle once the first slot begins.
module tb_serial_audio_encoder;
    import serial_audio_pkg::*;

    logic        sclk;
    logic        reset;
    logic        is_i2s;
    logic        lrclk_polarity;
    logic [1:0]  slot_width;
    logic        i_valid;
    logic        i_ready;
    logic        i_is_left;
    logic [31:0] i_audio;
    logic        lrclk_out;
    logic        sdout;
    logic        is_error;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          chk_start = 32'h3FFF_FFFF;
    int          exp_idx = 0;
    logic        prev_lj;
    logic        rdy_prev;
    logic [32:0] feed_q[$];
    logic [2:0]  exp_q[$];

    serial_audio_encoder dut (
        .sclk           (sclk),
        .reset          (reset),
        .is_i2s         (is_i2s),
        .lrclk_polarity (lrclk_polarity),
        .slot_width     (slot_width),
        .i_valid        (i_valid),
        .i_ready        (i_ready),
        .i_is_left      (i_is_left),
        .i_audio        (i_audio),
        .lrclk_out      (lrclk_out),
        .sdout          (sdout),
        .is_error       (is_error)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream checker: one expected entry per sclk cycle, sampled on the falling edge.
    always @(negedge sclk) begin
        logic [2:0] e;
        if (cyc >= chk_start && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("stream%0d", exp_idx), {29'd0, lrclk_out, sdout, is_error}, {29'd0, e});
            exp_idx++;
        end
    end

    // Feeder: presents queued words on the valid/ready stream, one transfer at a time.
    initial begin
        i_valid   = 1'b0;
        i_is_left = 1'b0;
        i_audio   = 32'h0000_0000;
        rdy_prev  = 1'b0;
        forever begin
            @(negedge sclk);
            if (reset) begin
                i_valid = 1'b0;
            end else begin
                if (i_valid && rdy_prev && feed_q.size() > 0) begin
                    void'(feed_q.pop_front());
                    i_valid = 1'b0;
                end
                if (!i_valid && feed_q.size() > 0) begin
                    {i_is_left, i_audio} = feed_q[0];
                    i_valid = 1'b1;
                end
            end
            rdy_prev = i_ready;
        end
    end

    task automatic feed(input logic left, input logic [31:0] w);
        feed_q.push_back({left, w});
    endtask

    // Expected slot: bit k carries data[31-k]; I2S shows the previous cycle's bit.
    task automatic push_slot(input logic left, input logic [31:0] data, input logic err,
                             input int n, input logic i2s, input logic pol);
        logic lj;
        logic sd;
        for (int k = 0; k < n; k++) begin
            lj = data[31-k];
            sd = i2s ? prev_lj : lj;
            prev_lj = lj;
            exp_q.push_back({left ? pol : !pol, sd, err});
        end
    endtask

    task automatic do_reset(input logic pol, input logic i2s, input logic [1:0] sw);
        reset = 1'b1;
        feed_q.delete();
        exp_q.delete();
        prev_lj = 1'b0;
        lrclk_polarity = pol;
        is_i2s = i2s;
        slot_width = sw;
        #1;
        chk("rst_lrclk", 32'(lrclk_out), 32'(!pol));
        chk("rst_sdout", 32'(sdout), 32'd0);
        chk("rst_ready", 32'(i_ready), 32'd1);
        chk("rst_error", 32'(is_error), 32'd0);
        repeat (2) @(posedge sclk);
        #1 reset = 1'b0;
        @(posedge sclk);
        #1;
        chk("idle_lrclk", 32'(lrclk_out), 32'(!pol));
        chk("idle_ready", 32'(i_ready), 32'd1);
    endtask

    // Called one step after a posedge: the first slot starts two edges later.
    task automatic start_scn();
        chk_start = cyc + 2;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge sclk);
        #1;
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1;

        // Left-justified 32-bit, polarity 1.
        do_reset(1'b1, 1'b0, SW_32);
        start_scn();
        feed(1'b1, 32'hA5A5_0001);
        feed(1'b0, 32'h8000_0000);
        push_slot(1'b1, 32'hA5A5_0001, 1'b0, 32, 1'b0, 1'b1);
        push_slot(1'b0, 32'h8000_0000, 1'b0, 32, 1'b0, 1'b1);
        drain("lj32_drain");

        // I2S 24-bit, polarity 0; third slot is an underrun carrying the previous LSB on its edge.
        do_reset(1'b0, 1'b1, SW_24);
        start_scn();
        feed(1'b1, 32'h1234_5600);
        feed(1'b0, 32'hABCD_EF00);
        push_slot(1'b1, 32'h1234_5600, 1'b0, 24, 1'b1, 1'b0);
        push_slot(1'b0, 32'hABCD_EF00, 1'b0, 24, 1'b1, 1'b0);
        push_slot(1'b1, 32'h0000_0000, 1'b1, 24, 1'b1, 1'b0);
        drain("i2s24_drain");

        // 16-bit left-justified random words: only the top half is sent.
        do_reset(1'b0, 1'b0, SW_16);
        start_scn();
        for (int i = 0; i < 8; i++) begin
            w = $urandom();
            feed((i % 2) == 0, w);
            push_slot((i % 2) == 0, w & 32'hFFFF_0000, 1'b0, 16, 1'b0, 1'b0);
        end
        drain("rand16_drain");

        // Underrun: right word withheld, next left word supplied after the right slot started.
        do_reset(1'b1, 1'b0, SW_16);
        start_scn();
        feed(1'b1, 32'hC3C3_0000);
        push_slot(1'b1, 32'hC3C3_0000, 1'b0, 16, 1'b0, 1'b1);
        push_slot(1'b0, 32'h0000_0000, 1'b1, 16, 1'b0, 1'b1);
        push_slot(1'b1, 32'h5A5A_0000, 1'b0, 16, 1'b0, 1'b1);
        push_slot(1'b0, 32'h0001_0000, 1'b0, 16, 1'b0, 1'b1);
        repeat (22) @(posedge sclk);
        #1;
        feed(1'b1, 32'h5A5A_0000);
        feed(1'b0, 32'h0001_0000);
        drain("underrun_drain");

        // Misorder: two left words back-to-back; the second is dropped at the right-slot start.
        do_reset(1'b1, 1'b0, SW_16);
        start_scn();
        feed(1'b1, 32'hF00F_0000);
        feed(1'b1, 32'hFFFF_0000);
        push_slot(1'b1, 32'hF00F_0000, 1'b0, 16, 1'b0, 1'b1);
        push_slot(1'b0, 32'h0000_0000, 1'b1, 16, 1'b0, 1'b1);
        push_slot(1'b1, 32'h8001_0000, 1'b0, 16, 1'b0, 1'b1);
        push_slot(1'b0, 32'h7FFE_0000, 1'b0, 16, 1'b0, 1'b1);
        repeat (22) @(posedge sclk);
        #1;
        feed(1'b1, 32'h8001_0000);
        feed(1'b0, 32'h7FFE_0000);
        drain("misorder_drain");

        // Slot width 32 -> 16 during the right slot: applies from the next frame only.
        do_reset(1'b1, 1'b0, SW_32);
        start_scn();
        feed(1'b1, 32'hDEAD_BEEF);
        feed(1'b0, 32'h0123_4567);
        feed(1'b1, 32'hCAFE_0000);
        feed(1'b0, 32'h8888_0000);
        push_slot(1'b1, 32'hDEAD_BEEF, 1'b0, 32, 1'b0, 1'b1);
        push_slot(1'b0, 32'h0123_4567, 1'b0, 32, 1'b0, 1'b1);
        push_slot(1'b1, 32'hCAFE_0000, 1'b0, 16, 1'b0, 1'b1);
        push_slot(1'b0, 32'h8888_0000, 1'b0, 16, 1'b0, 1'b1);
        repeat (40) @(posedge sclk);
        #1 slot_width = SW_16;
        drain("swchg_drain");

        // Reset in the middle of a left slot with a word waiting in the holding register.
        do_reset(1'b1, 1'b0, SW_32);
        start_scn();
        feed(1'b1, 32'hFFFF_FFFF);
        feed(1'b1, 32'h0F0F_0F0F);
        push_slot(1'b1, 32'hFFFF_FFFF, 1'b0, 32, 1'b0, 1'b1);
        repeat (9) @(posedge sclk);
        #3;
        chk("pre_rst_lrclk", 32'(lrclk_out), 32'd1);
        chk("pre_rst_sdout", 32'(sdout), 32'd1);
        chk("pre_rst_ready", 32'(i_ready), 32'd0);
        do_reset(1'b1, 1'b0, SW_32);
        slot_width = SW_16;
        start_scn();
        feed(1'b1, 32'h1234_0000);
        feed(1'b0, 32'hFEDC_0000);
        push_slot(1'b1, 32'h1234_0000, 1'b0, 16, 1'b0, 1'b1);
        push_slot(1'b0, 32'hFEDC_0000, 1'b0, 16, 1'b0, 1'b1);
        drain("recover_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
